// File: rtl/display_pkg.sv
// display_pkg: shared types, defaults and blank-pattern helper for the display blocks.
package display_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {LIVE, HOLD} mode_t;
  localparam int DEF_NUM_HEX = 5;
  localparam int DEF_NUM_LED = 5;
  function automatic seg_t blank_seg(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction
endpackage

// File: rtl/display_timebase.sv
// display_timebase: free-running blink phase and PWM counter shared by display blocks.
module display_timebase #(
  parameter int BLINK_HALF = 25_000_000,
  parameter int PWM_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             phase,
  output logic [PWM_W-1:0] pwm_cnt
);
  localparam int CW = $clog2(BLINK_HALF);
  logic [CW-1:0] blink_cnt;
  logic wrap;
  assign wrap = blink_cnt == CW'(BLINK_HALF - 1);
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      blink_cnt <= '0;
      phase <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      phase <= phase ^ wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
endmodule

// File: rtl/display_output_stage.sv
// display_output_stage: registered 7-seg/LED pin stage with hold/load capture, blinking and PWM dimming.
module display_output_stage
  import display_pkg::*;
#(
  parameter int NUM_HEX = DEF_NUM_HEX,
  parameter int NUM_LED = DEF_NUM_LED,
  parameter int BLINK_HALF = 25_000_000,
  parameter int PWM_W = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_HEX-1:0][6:0] i_HEXs,
  input  logic [NUM_LED-1:0]      i_LEDs,
  input  logic                    i_hold,
  input  logic                    i_load,
  input  logic [NUM_HEX-1:0]      i_hex_blink,
  input  logic [NUM_LED-1:0]      i_led_blink,
  input  logic [PWM_W-1:0]        i_brightness,
  output logic [NUM_HEX-1:0][6:0] o_HEXs,
  output logic [NUM_LED-1:0]      o_LEDs,
  output logic                    o_holding
);
  localparam seg_t BLANK = blank_seg(SEG_ACTIVE_LOW != 0);
  mode_t state, state_next;
  logic [NUM_HEX-1:0][6:0] cap_hex;
  logic [NUM_LED-1:0] cap_led;
  logic [PWM_W-1:0] pwm_cnt;
  logic phase, pwm_on, cap_en;
  display_timebase #(.BLINK_HALF(BLINK_HALF), .PWM_W(PWM_W)) u_timebase (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .phase(phase),
    .pwm_cnt(pwm_cnt)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= LIVE;
    else state <= state_next;
  always_comb begin
    state_next = i_hold ? HOLD : LIVE;
  end
  // LIVE captures every cycle, so the sample on the edge that enters HOLD is the frozen one
  assign cap_en = (state == LIVE) || i_load;
  assign pwm_on = (&i_brightness) || (pwm_cnt < i_brightness);
  assign o_holding = state == HOLD;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      cap_hex <= {NUM_HEX{BLANK}};
      cap_led <= '0;
      o_HEXs <= {NUM_HEX{BLANK}};
      o_LEDs <= '0;
    end else begin
      if (cap_en) begin
        cap_hex <= i_HEXs;
        cap_led <= i_LEDs;
      end
      for (int i = 0; i < NUM_HEX; i++)
        o_HEXs[i] <= (!pwm_on || (i_hex_blink[i] && phase)) ? BLANK : cap_hex[i];
      o_LEDs <= cap_led & {NUM_LED{pwm_on}} & ~(i_led_blink & {NUM_LED{phase}});
    end
endmodule

// File: tb/tb_display_output_stage.sv
// tb_display_output_stage: directed vector table plus blink, PWM, reset and wide-parameter sequences.
module tb_display_output_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [4:0][6:0] hex_in, o_hex;
  logic [4:0] led_in, hex_blink, led_blink, o_led;
  logic hold, load, holding;
  logic [3:0] bright;
  logic [7:0][6:0] hex_in_b, o_hex_b;
  logic [9:0] led_in_b, o_led_b;
  logic holding_b;
  logic zero_b = 1'b0;
  logic [7:0] hb_b = '0;
  logic [9:0] lb_b = '0;
  logic [3:0] br_b = 4'hF;

  display_output_stage #(.NUM_HEX(5), .NUM_LED(5), .BLINK_HALF(4), .PWM_W(4), .SEG_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_HEXs(hex_in), .i_LEDs(led_in), .i_hold(hold), .i_load(load),
    .i_hex_blink(hex_blink), .i_led_blink(led_blink), .i_brightness(bright),
    .o_HEXs(o_hex), .o_LEDs(o_led), .o_holding(holding));

  display_output_stage #(.NUM_HEX(8), .NUM_LED(10), .BLINK_HALF(4), .PWM_W(4), .SEG_ACTIVE_LOW(0)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_HEXs(hex_in_b), .i_LEDs(led_in_b), .i_hold(zero_b), .i_load(zero_b),
    .i_hex_blink(hb_b), .i_led_blink(lb_b), .i_brightness(br_b),
    .o_HEXs(o_hex_b), .o_LEDs(o_led_b), .o_holding(holding_b));

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_blink(input string tag);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk({tag, "_holding"}, 64'(holding), 64'(0));
      if (k >= 2) begin
        int ph;
        ph = ((k - 1) / 4) % 2;
        chk({tag, "_hex0"}, 64'(o_hex[0]), ph ? 64'h7F : 64'h5A);
        chk({tag, "_hex1"}, 64'(o_hex[1]), 64'h5A);
        chk({tag, "_led"}, 64'(o_led), ph ? 64'h1D : 64'h1F);
      end
    end
  endtask

  typedef struct {
    logic hold; logic load; logic [6:0] hex; logic [4:0] led;
    logic [6:0] exp_hex; logic [4:0] exp_led; logic exp_holding;
  } vec_t;
  vec_t v[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0] = '{1'b0, 1'b0, 7'h11, 5'h01, 7'h7F, 5'h00, 1'b0};
    v[1] = '{1'b0, 1'b0, 7'h22, 5'h02, 7'h11, 5'h01, 1'b0};
    v[2] = '{1'b1, 1'b0, 7'h33, 5'h03, 7'h22, 5'h02, 1'b1};
    v[3] = '{1'b1, 1'b0, 7'h44, 5'h04, 7'h33, 5'h03, 1'b1};
    v[4] = '{1'b1, 1'b0, 7'h55, 5'h05, 7'h33, 5'h03, 1'b1};
    v[5] = '{1'b1, 1'b1, 7'h66, 5'h06, 7'h33, 5'h03, 1'b1};
    v[6] = '{1'b1, 1'b0, 7'h77, 5'h07, 7'h66, 5'h06, 1'b1};
    v[7] = '{1'b0, 1'b1, 7'h08, 5'h08, 7'h66, 5'h06, 1'b0};
    v[8] = '{1'b0, 1'b0, 7'h09, 5'h09, 7'h08, 5'h08, 1'b0};
    v[9] = '{1'b0, 1'b0, 7'h0A, 5'h0A, 7'h09, 5'h09, 1'b0};
    rst_n = 1'b0;
    hex_in = {5{7'h40}}; led_in = 5'h1F; hold = 0; load = 0;
    hex_blink = '0; led_blink = '0; bright = 4'hF;
    hex_in_b = '0; led_in_b = '0;
    step();
    step();
    chk("rst_hex", 64'(o_hex), 64'({5{7'h7F}}));
    chk("rst_led", 64'(o_led), 64'(0));
    chk("rst_holding", 64'(holding), 64'(0));
    chk("rst_hex_b", 64'(o_hex_b), 64'(0));
    chk("rst_led_b", 64'(o_led_b), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hold = v[i].hold; load = v[i].load;
      hex_in = {5{v[i].hex}}; led_in = v[i].led;
      step();
      chk($sformatf("vec%0d_hex", i), 64'(o_hex), 64'({5{v[i].exp_hex}}));
      chk($sformatf("vec%0d_led", i), 64'(o_led), 64'(v[i].exp_led));
      chk($sformatf("vec%0d_holding", i), 64'(holding), 64'(v[i].exp_holding));
    end
    hold = 0; load = 0;
    // Restart the timebase so blink phase is known
    rst_n = 1'b0;
    hex_in = {5{7'h5A}}; led_in = 5'h1F; hex_blink = 5'b00001; led_blink = 5'b00010;
    #2 rst_n = 1'b1;
    run_blink("blink");
    hex_blink = '0; led_blink = '0;
    for (int j = 0; j < 3; j++) begin
      int lit_h, lit_l, bad, expn;
      bright = (j == 0) ? 4'd0 : (j == 1) ? 4'd4 : 4'd15;
      expn = (j == 0) ? 0 : (j == 1) ? 4 : 16;
      lit_h = 0; lit_l = 0; bad = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (o_hex == {5{7'h5A}}) lit_h++;
        else if (o_hex != {5{7'h7F}}) bad++;
        if (o_led == 5'h1F) lit_l++;
        else if (o_led != 5'h00) bad++;
      end
      chk($sformatf("pwm%0d_hex_lit", bright), 64'(lit_h), 64'(expn));
      chk($sformatf("pwm%0d_led_lit", bright), 64'(lit_l), 64'(expn));
      chk($sformatf("pwm%0d_bad", bright), 64'(bad), 64'(0));
    end
    bright = 4'hF; hex_blink = 5'b00001; led_blink = 5'b00010; hold = 1;
    for (int k = 0; k < 7; k++) step();
    chk("hold_before_rst", 64'(holding), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hex", 64'(o_hex), 64'({5{7'h7F}}));
    chk("async_rst_led", 64'(o_led), 64'(0));
    chk("async_rst_holding", 64'(holding), 64'(0));
    hold = 0;
    #1 rst_n = 1'b1;
    run_blink("post_rst");
    begin
      logic [7:0][6:0] pb_prev, pb_cur;
      logic [9:0] lb_prev, lb_cur;
      step();
      rst_n = 1'b0;
      #1;
      chk("b_rst_hex", 64'(o_hex_b), 64'(0));
      chk("b_rst_led", 64'(o_led_b), 64'(0));
      #1 rst_n = 1'b1;
      pb_prev = '0; lb_prev = '0;
      for (int k = 0; k < 6; k++) begin
        for (int d = 0; d < 8; d++) pb_cur[d] = 7'((k * 13 + d * 5 + 1) & 7'h7F);
        lb_cur = 10'((k * 77 + 5) & 10'h3FF);
        hex_in_b = pb_cur; led_in_b = lb_cur;
        step();
        chk($sformatf("b%0d_hex", k), 64'(o_hex_b), 64'(pb_prev));
        chk($sformatf("b%0d_led", k), 64'(o_led_b), 64'(lb_prev));
        pb_prev = pb_cur; lb_prev = lb_cur;
      end
      chk("b_holding", 64'(holding_b), 64'(0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
